mc_control: RTL

Multicycle MIPS control unit. It replaces the single-cycle main decoder with a Moore FSM that sequences a shared-memory datapath (one memory for instructions and data, one ALU reused for PC increment and branch-target computation) over 3-5 cycles per instruction. It sits beside the datapath, takes the opcode from the instruction register and a memory-ready handshake, and drives every datapath mux/enable. It also counts retired instructions for performance debug.

---
 rtl/mc_pkg.sv | 62 ++++++
 rtl/mc_outdec.sv | 76 +++++++
 rtl/mc_control.sv | 108 ++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
// Holds the state enum, opcodes, datapath mux encodings and the control-word struct.
package mc_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEMADR   = 4'd2,
        ST_MEMREAD  = 4'd3,
        ST_MEMWB    = 4'd4,
        ST_MEMWRITE = 4'd5,
        ST_EXECUTE  = 4'd6,
        ST_ALUWB    = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_ADDIEX   = 4'd9,
        ST_ADDIWB   = 4'd10,
        ST_JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Raw per-state control word; ir_write/pc_write are gated by mem_ready in the top.
    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       mem_write;
        logic       mem_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_instruc;
        logic [1:0] pc_src;
        logic       branch;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/mc_outdec.sv
// Combinational state -> control-word decoder for the multicycle control unit.
// Anything not assigned for a state stays at zero.
module mc_outdec
    import mc_pkg::*;
(
    input  state_t state_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        unique case (state_i)
            ST_FETCH: begin
                ctrl_o.mem_req     = 1'b1;
                ctrl_o.iord        = 1'b0;
                ctrl_o.ir_write    = 1'b1;
                ctrl_o.pc_write    = 1'b1;
                ctrl_o.alu_src_a   = 1'b0;
                ctrl_o.alu_src_b   = SRCB_FOUR;
                ctrl_o.alu_instruc = ALUOP_ADD;
                ctrl_o.pc_src      = PCSRC_ALU;
            end
            ST_DECODE: begin
                // Speculative branch target: PC + (imm << 2) into ALUOut.
                ctrl_o.alu_src_a   = 1'b0;
                ctrl_o.alu_src_b   = SRCB_IMMSH;
                ctrl_o.alu_instruc = ALUOP_ADD;
            end
            ST_MEMADR, ST_ADDIEX: begin
                ctrl_o.alu_src_a   = 1'b1;
                ctrl_o.alu_src_b   = SRCB_IMM;
                ctrl_o.alu_instruc = ALUOP_ADD;
            end
            ST_MEMREAD: begin
                ctrl_o.mem_req = 1'b1;
                ctrl_o.iord    = 1'b1;
            end
            ST_MEMWRITE: begin
                ctrl_o.mem_req   = 1'b1;
                ctrl_o.iord      = 1'b1;
                ctrl_o.mem_write = 1'b1;
            end
            ST_MEMWB: begin
                ctrl_o.mem_reg   = 1'b1;
                ctrl_o.reg_dst   = 1'b0;
                ctrl_o.reg_write = 1'b1;
            end
            ST_EXECUTE: begin
                ctrl_o.alu_src_a   = 1'b1;
                ctrl_o.alu_src_b   = SRCB_REG;
                ctrl_o.alu_instruc = ALUOP_FUNCT;
            end
            ST_ALUWB: begin
                ctrl_o.reg_dst   = 1'b1;
                ctrl_o.reg_write = 1'b1;
            end
            ST_ADDIWB: begin
                ctrl_o.reg_dst   = 1'b0;
                ctrl_o.reg_write = 1'b1;
            end
            ST_BRANCH: begin
                ctrl_o.alu_src_a   = 1'b1;
                ctrl_o.alu_src_b   = SRCB_REG;
                ctrl_o.alu_instruc = ALUOP_SUB;
                ctrl_o.pc_src      = PCSRC_ALUOUT;
                ctrl_o.branch      = 1'b1;
            end
            ST_JUMP: begin
                ctrl_o.pc_src   = PCSRC_JUMP;
                ctrl_o.pc_write = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS control FSM: sequences the shared-memory datapath, gates fetch
// on the memory handshake and counts retired instructions.
module mc_control
    import mc_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [5:0]          instruc,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                iord,
    output logic                ir_write,
    output logic                mem_write,
    output logic                mem_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_instruc,
    output logic [1:0]          pc_src,
    output logic                pc_en,
    output logic                illegal_op,
    output logic [RETIRE_W-1:0] retired
);

    state_t              state_q, state_d;
    state_t              out_state;
    ctrl_t               ctrl;
    logic [RETIRE_W-1:0] retired_q, retired_d;
    logic                retire_now;
    logic                pc_write_g;

    // While reset is held the datapath sees FETCH controls, not the stale state.
    assign out_state = reset ? ST_FETCH : state_q;

    mc_outdec u_outdec (
        .state_i (out_state),
        .ctrl_o  (ctrl)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_FETCH:    if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                case (instruc)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_RTYPE:     state_d = ST_EXECUTE;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_ADDI:      state_d = ST_ADDIEX;
                    OP_J:         state_d = ST_JUMP;
                    default:      state_d = ST_FETCH;
                endcase
            end
            // Anything other than sw falls to a harmless read rather than a write.
            ST_MEMADR:   state_d = (instruc == OP_SW) ? ST_MEMWRITE : ST_MEMREAD;
            ST_MEMREAD:  if (mem_ready) state_d = ST_MEMWB;
            ST_MEMWRITE: if (mem_ready) state_d = ST_FETCH;
            ST_EXECUTE:  state_d = ST_ALUWB;
            ST_ADDIEX:   state_d = ST_ADDIWB;
            ST_MEMWB, ST_ALUWB, ST_ADDIWB, ST_BRANCH, ST_JUMP:
                         state_d = ST_FETCH;
            default:     state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        retire_now = 1'b0;
        case (state_q)
            ST_MEMWB, ST_ALUWB, ST_ADDIWB, ST_BRANCH, ST_JUMP: retire_now = 1'b1;
            ST_MEMWRITE: retire_now = mem_ready;
            default:     retire_now = 1'b0;
        endcase
        retired_d = retire_now ? retired_q + {{(RETIRE_W-1){1'b0}}, 1'b1} : retired_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // A stalled fetch must not advance PC or IR.
    assign pc_write_g  = (out_state == ST_FETCH) ? (ctrl.pc_write & mem_ready) : ctrl.pc_write;

    assign mem_req     = ctrl.mem_req;
    assign iord        = ctrl.iord;
    assign ir_write    = ctrl.ir_write & mem_ready;
    assign mem_write   = ctrl.mem_write;
    assign mem_reg     = ctrl.mem_reg;
    assign reg_dst     = ctrl.reg_dst;
    assign reg_write   = ctrl.reg_write;
    assign alu_src_a   = ctrl.alu_src_a;
    assign alu_src_b   = ctrl.alu_src_b;
    assign alu_instruc = ctrl.alu_instruc;
    assign pc_src      = ctrl.pc_src;
    assign pc_en       = pc_write_g | (ctrl.branch & zero);
    assign illegal_op  = (out_state == ST_DECODE) && !is_legal_op(instruc);
    assign retired     = retired_q;

endmodule
